sp_ram_req_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the single-port RAM (mem_wren/mem_rden/mem_addr/mem_wdata in, mem_rdata out, registered read, write has priority).
- Converts a valid/ready request stream into RAM strobes.
- Zero-fills the RAM after reset.
- Returns read data through a 2-entry valid/ready response buffer, so the RAM's hold-last-rdata behaviour never leaks to consumers.

---
 rtl/sp_ram_req_ctrl_pkg.sv | 20 ++
 rtl/sp_ram_req_ctrl_if.sv | 28 ++
 rtl/sp_ram_req_ctrl_rsp_fifo.sv | 63 ++++++
 rtl/sp_ram_req_ctrl.sv | 125 ++++++++++++
 tb/tb_sp_ram_req_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_req_ctrl_pkg.sv
// Shared types and constants for the single-port RAM request controller.
package sp_ram_ctrl_pkg;

  // Controller phases: one idle cycle after reset, optional zero-fill, then service.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Response buffer depth and the number of reads that may be outstanding
  // (in the RAM pipeline plus already buffered) at any time.
  localparam int RSP_DEPTH    = 2;
  localparam int CREDIT_LIMIT = RSP_DEPTH;

  // Width of the buffer occupancy count (must hold 0..RSP_DEPTH).
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);

endpackage

// File: rtl/sp_ram_req_ctrl_if.sv
// Request/response stream bundle between a requester and the RAM controller.
interface sp_ram_req_ctrl_if #(
  parameter int ABITS = 4,
  parameter int WIDTH = 8
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ABITS-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;

  // Requester side: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Controller side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sp_ram_req_ctrl_rsp_fifo.sv
// Two-entry first-word-fall-through response buffer. The head entry is read
// straight out of the storage registers, so data is visible the cycle after push.
module sp_ram_rsp_fifo
  import sp_ram_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic [WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of evaluation order.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: data storage is deliberately not reset; validity comes from r_count,
    // so clearing the entries would only add reset fan-out.
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/sp_ram_req_ctrl.sv
// Request-side controller for a single-port RAM with registered read data.
// Zero-fills the RAM after reset, turns a valid/ready request stream into RAM
// strobes and returns read data through a small credit-managed response buffer.
module sp_ram_req_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int ABITS         = 4,
  parameter int WIDTH         = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sp_ram_req_ctrl_if.slave bus,
  output logic             o_init_busy,
  output logic             o_mem_wren,
  output logic             o_mem_rden,
  output logic [ABITS-1:0] o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  localparam logic [ABITS-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(CREDIT_LIMIT);

  state_e           r_state;
  logic [ABITS-1:0] r_init_cnt;
  logic             r_init_busy;
  logic             r_inflight;

  logic [WIDTH-1:0] w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W-1:0] w_used;
  logic             w_ready;
  logic             w_acc;
  logic             w_push;
  logic             w_pop;

  // Credits: a read in the RAM pipeline plus buffered responses never exceed
  // the buffer depth. Ready ignores req_write so it never depends on request
  // contents; writes therefore also wait while read credit is exhausted.
  assign w_used  = CNT_W'(r_inflight) + w_fifo_count;
  assign w_ready = (r_state == ST_RUN) && (w_used < LIMIT_C);
  assign w_acc   = bus.req_valid & w_ready;

  // RAM read data is only meaningful the cycle after a read strobe.
  assign w_pop  = ~w_fifo_empty & bus.rsp_ready;
  assign w_push = r_inflight & (~w_fifo_full | w_pop);

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = ~w_fifo_empty;
  assign bus.rsp_rdata = w_fifo_rdata;
  assign o_init_busy   = r_init_busy;

  // Phase sequencing, zero-fill address counter and read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_START;
      r_init_cnt  <= '0;
      r_init_busy <= INIT_ON_RESET;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_acc & ~bus.req_write;
      case (r_state)
        ST_START: begin
          r_state <= INIT_ON_RESET ? ST_INIT : ST_RUN;
        end
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + ABITS'(1);
          if (r_init_cnt == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_START;
        end
      endcase
    end
  end

  // RAM strobe mux: fill writes during INIT, accepted requests during RUN.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    o_mem_wren  = 1'b0;
    o_mem_rden  = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      ST_INIT: begin
        o_mem_wren = 1'b1;
        o_mem_addr = r_init_cnt;
      end
      ST_RUN: begin
        if (w_acc) begin
          o_mem_wren  = bus.req_write;
          o_mem_rden  = ~bus.req_write;
          o_mem_addr  = bus.req_addr;
          o_mem_wdata = bus.req_wdata;
        end
      end
      default: ;
    endcase
  end

  sp_ram_rsp_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (i_mem_rdata),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Self-checking bench for sp_ram_req_ctrl: a behavioural single-port RAM, a
// reference memory image feeding a response scoreboard, a per-cycle vector table
// and hand-written sequences for fill, reset and idle-without-fill behaviour.
module tb_sp_ram_req_ctrl;
  import sp_ram_ctrl_pkg::*;

  localparam int ABITS = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 1 << ABITS;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT with zero-fill
  sp_ram_req_ctrl_if #(.ABITS(ABITS), .WIDTH(WIDTH)) bus ();
  logic             init_busy, mem_wren, mem_rden;
  logic [ABITS-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  sp_ram_req_ctrl #(.ABITS(ABITS), .WIDTH(WIDTH), .INIT_ON_RESET(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_init_busy (init_busy),
    .o_mem_wren  (mem_wren),
    .o_mem_rden  (mem_rden),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // DUT without zero-fill, left idle
  sp_ram_req_ctrl_if #(.ABITS(ABITS), .WIDTH(WIDTH)) bus0 ();
  logic             init_busy0, mem_wren0, mem_rden0;
  logic [ABITS-1:0] mem_addr0;
  logic [WIDTH-1:0] mem_wdata0;
  logic [WIDTH-1:0] mem_rdata0;
  assign mem_rdata0 = '0;

  sp_ram_req_ctrl #(.ABITS(ABITS), .WIDTH(WIDTH), .INIT_ON_RESET(1'b0)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus0),
    .o_init_busy (init_busy0),
    .o_mem_wren  (mem_wren0),
    .o_mem_rden  (mem_rden0),
    .o_mem_addr  (mem_addr0),
    .o_mem_wdata (mem_wdata0),
    .i_mem_rdata (mem_rdata0)
  );

  // Single-port RAM: registered read, write has priority, rdata holds otherwise.
  logic             ram_scrub = 1'b0;
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_scrub) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hEE;
      mem_rdata <= 8'hEE;
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end else if (mem_rden) begin
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference memory image and expected response queue.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] sb_q [$];

  int n_wren0 = 0;
  always @(negedge clk) if (mem_wren0) n_wren0++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outstanding reads plus buffered responses stay within the buffer depth.
  always @(negedge clk) begin
    if (rst_n) begin
      int used;
      used = int'(dut.r_inflight) + int'(dut.w_fifo_count);
      check("credit_bound", (used <= 2) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  // One clock of stimulus: drive at negedge, observe 2 ns later.
  task automatic drive_cycle(input logic v, input logic w, input logic [ABITS-1:0] a,
                             input logic [WIDTH-1:0] d, input logic rr, input bit chk,
                             input logic exp_ready, input logic exp_rspv, input string tag);
    logic acc, exp_acc;
    logic [WIDTH-1:0] exp_data;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    #2;
    if (chk) begin
      exp_acc = v & exp_ready;
      check({tag, ":req_ready"}, bus.req_ready, exp_ready);
      check({tag, ":rsp_valid"}, bus.rsp_valid, exp_rspv);
      check({tag, ":mem_wren"}, mem_wren, exp_acc & w);
      check({tag, ":mem_rden"}, mem_rden, exp_acc & ~w);
      check({tag, ":mem_addr"}, mem_addr, exp_acc ? a : '0);
      check({tag, ":mem_wdata"}, mem_wdata, exp_acc ? d : '0);
    end
    if (bus.rsp_valid && rr) begin
      if (sb_q.size() == 0) begin
        check({tag, ":unexpected_rsp"}, 32'd1, 32'd0);
      end else begin
        exp_data = sb_q.pop_front();
        check({tag, ":rsp_rdata"}, bus.rsp_rdata, exp_data);
      end
    end
    acc = v & bus.req_ready;
    if (acc) begin
      if (w) ref_mem[a] = d;
      else   sb_q.push_back(ref_mem[a]);
    end
  endtask

  // Release reset and follow START plus the full zero-fill.
  task automatic release_and_check_fill(input bit with_dut0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("start:mem_wren", mem_wren, 0);
    check("start:req_ready", bus.req_ready, 0);
    check("start:init_busy", init_busy, 1);
    if (with_dut0) begin
      check("noinit:start_ready", bus0.req_ready, 0);
      check("noinit:init_busy", init_busy0, 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      #2;
      check($sformatf("fill%0d:mem_wren", i), mem_wren, 1);
      check($sformatf("fill%0d:mem_addr", i), mem_addr, i);
      check($sformatf("fill%0d:mem_wdata", i), mem_wdata, 0);
      check($sformatf("fill%0d:req_ready", i), bus.req_ready, 0);
      check($sformatf("fill%0d:init_busy", i), init_busy, 1);
      if (with_dut0 && i == 0) check("noinit:second_cycle_ready", bus0.req_ready, 1);
    end
    @(negedge clk);
    #2;
    check("run:init_busy", init_busy, 0);
    check("run:req_ready", bus.req_ready, 1);
    check("run:mem_wren", mem_wren, 0);
    for (int j = 0; j < DEPTH; j++) ref_mem[j] = '0;
  endtask

  typedef struct packed {
    logic             v;
    logic             w;
    logic [ABITS-1:0] a;
    logic [WIDTH-1:0] d;
    logic             rr;
    logic             exp_ready;
    logic             exp_rspv;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic w, input logic [ABITS-1:0] a,
                              input logic [WIDTH-1:0] d, input logic rr,
                              input logic er, input logic ev);
    mk = '{v, w, a, d, rr, er, ev};
  endfunction

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              v  w  addr   data   rr exp_ready exp_rsp_valid
    vecs[0]  = mk(H, L, 4'h9, 8'h00, H, H, L);  // fresh RAM reads return 0
    vecs[1]  = mk(H, L, 4'hF, 8'h00, H, H, L);
    vecs[2]  = mk(L, L, 4'h0, 8'h00, H, L, H);  // one in flight + one buffered
    vecs[3]  = mk(L, L, 4'h0, 8'h00, H, H, H);
    vecs[4]  = mk(L, L, 4'h0, 8'h00, H, H, L);
    vecs[5]  = mk(H, H, 4'h3, 8'hA5, H, H, L);  // write then read same address
    vecs[6]  = mk(H, L, 4'h3, 8'h00, H, H, L);
    vecs[7]  = mk(L, L, 4'h0, 8'h00, H, H, L);
    vecs[8]  = mk(L, L, 4'h0, 8'h00, H, H, H);  // exactly 2 cycles after accept
    vecs[9]  = mk(L, L, 4'h0, 8'h00, H, H, L);
    vecs[10] = mk(H, H, 4'h0, 8'h10, H, H, L);  // preload 0..3
    vecs[11] = mk(H, H, 4'h1, 8'h11, H, H, L);
    vecs[12] = mk(H, H, 4'h2, 8'h12, H, H, L);
    vecs[13] = mk(H, H, 4'h3, 8'h13, H, H, L);
    vecs[14] = mk(H, L, 4'h0, 8'h00, L, H, L);  // four reads, consumer stalled
    vecs[15] = mk(H, L, 4'h1, 8'h00, L, H, L);
    vecs[16] = mk(H, L, 4'h2, 8'h00, L, L, H);
    vecs[17] = mk(H, L, 4'h2, 8'h00, L, L, H);
    vecs[18] = mk(H, H, 4'h7, 8'h55, L, L, H);  // writes stall too
    vecs[19] = mk(H, L, 4'h2, 8'h00, H, L, H);  // consumer resumes
    vecs[20] = mk(H, L, 4'h2, 8'h00, H, H, H);
    vecs[21] = mk(H, L, 4'h3, 8'h00, H, H, L);
    vecs[22] = mk(L, L, 4'h0, 8'h00, H, L, H);
    vecs[23] = mk(L, L, 4'h0, 8'h00, H, H, H);
    vecs[24] = mk(H, H, 4'h5, 8'h22, H, H, L);  // read then write same address
    vecs[25] = mk(H, L, 4'h5, 8'h00, H, H, L);
    vecs[26] = mk(H, H, 4'h5, 8'h77, H, H, L);
    vecs[27] = mk(H, L, 4'h5, 8'h00, H, H, H);
    vecs[28] = mk(L, L, 4'h0, 8'h00, H, H, L);
    vecs[29] = mk(L, L, 4'h0, 8'h00, H, H, H);
    vecs[30] = mk(L, L, 4'h0, 8'h00, H, H, L);

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b1;

    // Reset held: RAM scrubbed to a non-zero pattern so the fill is observable.
    ram_scrub = 1'b1;
    repeat (2) @(negedge clk);
    ram_scrub = 1'b0;
    #2;
    check("rst:req_ready", bus.req_ready, 0);
    check("rst:rsp_valid", bus.rsp_valid, 0);
    check("rst:mem_wren", mem_wren, 0);
    check("rst:mem_rden", mem_rden, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:init_busy", init_busy, 1);
    check("rst:noinit_busy", init_busy0, 0);

    release_and_check_fill(1'b1);

    for (int i = 0; i < NVEC; i++)
      drive_cycle(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rr, 1'b1,
                  vecs[i].exp_ready, vecs[i].exp_rspv, $sformatf("vec%0d", i));
    check("vec:queue_empty", sb_q.size(), 0);

    // Random traffic on a few addresses to exercise hazards and stalls.
    for (int i = 0; i < 300; i++)
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ABITS'($urandom_range(0, 3)), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, "rand");
    for (int i = 0; i < 10; i++)
      if (sb_q.size() != 0 || bus.rsp_valid)
        drive_cycle(L, L, '0, '0, H, 1'b0, 1'b0, 1'b0, "drain");
    check("rand:queue_empty", sb_q.size(), 0);
    check("rand:rsp_valid_idle", bus.rsp_valid, 0);

    // Load the buffer, then reset with responses pending.
    drive_cycle(H, L, 4'h0, 8'h00, L, 1'b0, 1'b0, 1'b0, "load");
    drive_cycle(H, L, 4'h1, 8'h00, L, 1'b0, 1'b0, 1'b0, "load");
    drive_cycle(L, L, 4'h0, 8'h00, L, 1'b0, 1'b0, 1'b0, "load");
    check("load:rsp_valid", bus.rsp_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_full:rsp_valid", bus.rsp_valid, 0);
    check("rst_full:req_ready", bus.req_ready, 0);
    check("rst_full:mem_wren", mem_wren, 0);
    sb_q.delete();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    ram_scrub = 1'b1;
    @(negedge clk);
    ram_scrub = 1'b0;

    // Release, then reset again in the middle of the fill at address 7.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    check("midfill:mem_addr", mem_addr, 7);
    check("midfill:mem_wren", mem_wren, 1);
    rst_n = 1'b0;
    #1;
    check("midrst:mem_wren", mem_wren, 0);
    check("midrst:req_ready", bus.req_ready, 0);
    check("midrst:rsp_valid", bus.rsp_valid, 0);
    check("midrst:init_busy", init_busy, 1);
    repeat (2) @(negedge clk);

    release_and_check_fill(1'b0);

    // Previously written address reads back as zero after the refill.
    drive_cycle(H, L, 4'h3, 8'h00, H, 1'b1, H, L, "post0");
    drive_cycle(L, L, 4'h0, 8'h00, H, 1'b1, H, L, "post1");
    drive_cycle(L, L, 4'h0, 8'h00, H, 1'b1, H, H, "post2");
    drive_cycle(L, L, 4'h0, 8'h00, H, 1'b1, H, L, "post3");
    check("post:queue_empty", sb_q.size(), 0);

    check("noinit:wren_pulses", n_wren0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
